// File: rtl/chk_stim_pkg.sv
// Shared types and constants for the checker stimulus generator: FSM states,
// injected-violation kinds, the one-hot operand table and the LFSR taps.
package chk_stim_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        INJ_ZERO = 2'd0,
        INJ_EQ   = 2'd1,
        INJ_BIG  = 2'd2,
        INJ_TWO  = 2'd3
    } inj_kind_t;

    // Element [0] is 8'h01, element [3] is 8'h08.
    localparam logic [3:0][7:0] ONEHOT_TBL = {8'h08, 8'h04, 8'h02, 8'h01};

    // Feedback from bits 7,5,4,3.
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    function automatic logic [7:0] lfsr_next(input logic [7:0] l);
        return {l[6:0], ^(l & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/stim_lfsr8.sv
// 8-bit Fibonacci LFSR, shift-left; loads the seed on reset or load, steps on adv.
// A zero seed is replaced by 8'h01 so the register never locks up.
module stim_lfsr8
    import chk_stim_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] seed,
    input  logic       adv,
    output logic [7:0] q
);

    logic [7:0] seed_nz;
    assign seed_nz = (seed == 8'h00) ? 8'h01 : seed;

    always_ff @(posedge clk) begin
        if (rst || load) begin
            q <= seed_nz;
        end else if (adv) begin
            q <= lfsr_next(q);
        end
    end

endmodule

// File: rtl/chk_stim_gen.sv
// Stimulus generator for property checkers: emits count vectors (a, b, idx) under
// valid/ready, optionally replacing one vector with a deliberate violation.
module chk_stim_gen
    import chk_stim_pkg::*;
#(
    parameter logic [7:0] LFSR_SEED = 8'hA5,
    parameter int         IDX_DEPTH = 21,
    parameter int         IDX_STEP  = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] count,
    input  logic       inject_en,
    input  logic [1:0] inject_sel,
    input  logic [7:0] inject_at,
    input  logic       out_ready,
    output logic       out_valid,
    output logic [7:0] out_a,
    output logic [7:0] out_b,
    output logic [4:0] out_idx,
    output logic       busy,
    output logic       done,
    output logic [7:0] vec_cnt
);

    localparam logic [5:0] STEP6  = 6'(IDX_STEP);
    localparam logic [5:0] DEPTH6 = 6'(IDX_DEPTH);

    state_t     state, state_nxt;
    logic [7:0] cnt_q;
    logic       inj_en_q;
    inj_kind_t  inj_sel_q;
    logic [7:0] inj_at_q;
    logic [4:0] idx_q;
    logic [7:0] lfsr_q;
    logic       start_go;
    logic       accept;
    logic       last_acc;
    logic [5:0] idx_sum;
    logic [4:0] idx_nxt;
    logic [7:0] legal_a, legal_b, vec_a, vec_b;

    assign start_go = (state == ST_IDLE) && start;
    assign accept   = out_valid && out_ready;
    assign last_acc = accept && ((vec_cnt + 8'd1) == cnt_q);

    stim_lfsr8 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .load (start_go),
        .seed (LFSR_SEED),
        .adv  (accept),
        .q    (lfsr_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = (count != 8'd0) ? ST_RUN : ST_FIN;
            ST_RUN:  if (last_acc) state_nxt = ST_FIN;
            ST_FIN:  state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Index wraps by subtraction; IDX_STEP < IDX_DEPTH keeps one subtraction enough.
    assign idx_sum = {1'b0, idx_q} + STEP6;
    assign idx_nxt = (idx_sum >= DEPTH6) ? 5'(idx_sum - DEPTH6) : idx_sum[4:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= 8'd0;
            inj_en_q  <= 1'b0;
            inj_sel_q <= INJ_ZERO;
            inj_at_q  <= 8'd0;
            idx_q     <= 5'd0;
            vec_cnt   <= 8'd0;
        end else if (start_go) begin
            cnt_q     <= count;
            inj_en_q  <= inject_en && (inject_at < count);
            inj_sel_q <= inj_kind_t'(inject_sel);
            inj_at_q  <= inject_at;
            idx_q     <= 5'd0;
            vec_cnt   <= 8'd0;
        end else if (accept) begin
            idx_q     <= idx_nxt;
            vec_cnt   <= vec_cnt + 8'd1;
        end
    end

    // Payload is a pure function of held state, so it stays put while stalled.
    always_comb begin
        legal_a = ONEHOT_TBL[lfsr_q[1:0]];
        legal_b = (lfsr_q != legal_a) ? lfsr_q : ~legal_a;
        vec_a   = legal_a;
        vec_b   = legal_b;
        if (inj_en_q && (vec_cnt == inj_at_q)) begin
            case (inj_sel_q)
                INJ_ZERO: vec_a = 8'h00;
                INJ_EQ:   vec_b = legal_a;
                INJ_BIG:  vec_a = 8'h80;
                INJ_TWO:  vec_a = 8'h03;
                default:  vec_a = legal_a;
            endcase
        end
    end

    assign out_valid = (state == ST_RUN);
    assign busy      = (state == ST_RUN);
    assign done      = (state == ST_FIN);
    assign out_a     = out_valid ? vec_a : 8'h00;
    assign out_b     = out_valid ? vec_b : 8'h00;
    assign out_idx   = out_valid ? idx_q : 5'd0;

endmodule
